uc_multiciclo_param: RTL and testbench

Parametrised multicycle control unit for the RV64 datapath. It supersedes the fixed-sequence control unit and adds the following:
- a fetch/decode/execute FSM covering R-type, I-type ALU, load, store, branch and LUI;
- a memory request/ready handshake with a configurable wait timeout;
- an ebreak halt state.

It drives the mux selects, register load enables, ALU opcode and memory strobes of the datapath. It also consumes the opcode/funct fields from the instruction register and the ALU flags.

---
 rtl/uc_multiciclo_param.sv | 207 ++++++++++++++++++++
 tb/tb_uc_multiciclo_param.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo_param.sv
`timescale 1ns/1ps
// Multicycle control unit for the RV64 datapath: fetch/decode/execute FSM with a memory
// request/ready handshake, a wait timeout and ebreak halt. Define UC_TRAP_EN to trap undefined opcodes.
module uc_multiciclo_param #(
  parameter int ALU_W       = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [6:0]       IR6_0,
  input  logic [2:0]       IR14_12,
  input  logic             IR30,
  input  logic             IGUAL,
  input  logic             MEM_READY,
  output logic             MEM_REQ,
  output logic             MEM_WR,
  output logic             IR_WIRE,
  output logic             PC_WRITE,
  output logic             PC_SRC,
  output logic             ALU_SRCA,
  output logic [1:0]       ALU_SRCB,
  output logic [ALU_W-1:0] ALU_SELECTOR,
  output logic             LOAD_A,
  output logic             LOAD_B,
  output logic             LOAD_ALUOUT,
  output logic             LOAD_MDR,
  output logic             BANCO_WIRE,
  output logic [1:0]       MEM_TO_REG,
  output logic             HALTED,
  output logic             MEM_ERR
`ifdef UC_TRAP_EN
  , output logic           TRAP_SEL
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_ST,
    S_WB_ALU, S_WB_MEM, S_WB_LUI, S_BRANCH, S_HALT, S_ERR, S_TRAP
  } state_t;

  localparam logic [ALU_W-1:0] OP_ADD = ALU_W'(1);
  localparam logic [ALU_W-1:0] OP_SUB = ALU_W'(2);
  localparam logic [ALU_W-1:0] OP_AND = ALU_W'(3);
  localparam logic [ALU_W-1:0] OP_XOR = ALU_W'(6);
  localparam logic [ALU_W-1:0] OP_CMP = ALU_W'(7);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_hit;
  logic            br_taken;

  function automatic logic [ALU_W-1:0] exec_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? OP_SUB : OP_ADD;
      3'b111:  return OP_AND;
      3'b100:  return OP_XOR;
      default: return OP_ADD;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // This cycle would be the MEM_TIMEOUT-th wait; READY on the same cycle still completes.
  assign timeout_hit = (cnt_q == TO_LAST);
  assign br_taken    = ((IR14_12 == 3'b000) && IGUAL) || ((IR14_12 == 3'b001) && !IGUAL);

  always_comb begin
    state_d      = state_q;
    MEM_REQ      = 1'b0;
    MEM_WR       = 1'b0;
    IR_WIRE      = 1'b0;
    PC_WRITE     = 1'b0;
    PC_SRC       = 1'b0;
    ALU_SRCA     = 1'b0;
    ALU_SRCB     = 2'b00;
    ALU_SELECTOR = OP_ADD;
    LOAD_A       = 1'b0;
    LOAD_B       = 1'b0;
    LOAD_ALUOUT  = 1'b0;
    LOAD_MDR     = 1'b0;
    BANCO_WIRE   = 1'b0;
    MEM_TO_REG   = 2'b00;
    HALTED       = 1'b0;
    MEM_ERR      = 1'b0;
`ifdef UC_TRAP_EN
    TRAP_SEL     = 1'b0;
`endif
    // Outputs are held at their reset values for as long as RESET is low, not just at the edge.
    if (RESET) begin
      case (state_q)
        S_FETCH: begin
          MEM_REQ  = 1'b1;
          ALU_SRCB = 2'b01;
          if (MEM_READY) begin
            IR_WIRE  = 1'b1;
            PC_WRITE = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_ERR;
          end
        end
        S_DECODE: begin
          LOAD_A      = 1'b1;
          LOAD_B      = 1'b1;
          LOAD_ALUOUT = 1'b1;
          ALU_SRCB    = 2'b11;
          case (IR6_0)
            7'b0110011:             state_d = S_EXEC_R;
            7'b0010011:             state_d = S_EXEC_I;
            7'b0000011, 7'b0100011: state_d = S_ADDR;
            7'b1100011:             state_d = S_BRANCH;
            7'b0110111:             state_d = S_WB_LUI;
            7'b1110011:             state_d = S_HALT;
`ifdef UC_TRAP_EN
            default:                state_d = S_TRAP;
`else
            default:                state_d = S_FETCH;
`endif
          endcase
        end
        S_EXEC_R: begin
          ALU_SRCA     = 1'b1;
          ALU_SELECTOR = exec_op(IR14_12, IR30);
          LOAD_ALUOUT  = 1'b1;
          state_d      = S_WB_ALU;
        end
        S_EXEC_I: begin
          ALU_SRCA     = 1'b1;
          ALU_SRCB     = 2'b10;
          ALU_SELECTOR = exec_op(IR14_12, 1'b0);
          LOAD_ALUOUT  = 1'b1;
          state_d      = S_WB_ALU;
        end
        S_ADDR: begin
          ALU_SRCA    = 1'b1;
          ALU_SRCB    = 2'b10;
          LOAD_ALUOUT = 1'b1;
          state_d     = IR6_0[5] ? S_MEM_ST : S_MEM_RD;
        end
        S_MEM_RD: begin
          MEM_REQ = 1'b1;
          if (MEM_READY) begin
            LOAD_MDR = 1'b1;
            state_d  = S_WB_MEM;
          end else if (timeout_hit) begin
            state_d = S_ERR;
          end
        end
        S_MEM_ST: begin
          MEM_REQ = 1'b1;
          MEM_WR  = 1'b1;
          if (MEM_READY)        state_d = S_FETCH;
          else if (timeout_hit) state_d = S_ERR;
        end
        S_WB_ALU: begin
          BANCO_WIRE = 1'b1;
          state_d    = S_FETCH;
        end
        S_WB_MEM: begin
          BANCO_WIRE = 1'b1;
          MEM_TO_REG = 2'b01;
          state_d    = S_FETCH;
        end
        S_WB_LUI: begin
          BANCO_WIRE = 1'b1;
          MEM_TO_REG = 2'b10;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          ALU_SRCA     = 1'b1;
          ALU_SELECTOR = OP_CMP;
          PC_WRITE     = br_taken;
          PC_SRC       = br_taken;
          state_d      = S_FETCH;
        end
        S_HALT: HALTED = 1'b1;
        S_ERR: begin
          HALTED  = 1'b1;
          MEM_ERR = 1'b1;
        end
`ifdef UC_TRAP_EN
        S_TRAP: begin
          PC_WRITE = 1'b1;
          PC_SRC   = 1'b1;
          TRAP_SEL = 1'b1;
          state_d  = S_FETCH;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
    cnt_d = cnt_q;
    if (state_d != state_q)           cnt_d = '0;
    else if (MEM_REQ && !MEM_READY)   cnt_d = cnt_q + TO_W'(1);
  end

endmodule

// File: tb/tb_uc_multiciclo_param.sv
`timescale 1ns/1ps
// Directed bench for uc_multiciclo_param: walks each instruction class cycle by cycle and
// compares the packed control word against hand-written per-state values.
module tb_uc_multiciclo_param;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [6:0] IR6_0 = '0;
  logic [2:0] IR14_12 = '0;
  logic       IR30 = 1'b0;
  logic       IGUAL = 1'b0;
  logic       MEM_READY = 1'b0;
  logic       MEM_REQ, MEM_WR, IR_WIRE, PC_WRITE, PC_SRC, ALU_SRCA;
  logic [1:0] ALU_SRCB, MEM_TO_REG;
  logic [2:0] ALU_SELECTOR;
  logic       LOAD_A, LOAD_B, LOAD_ALUOUT, LOAD_MDR, BANCO_WIRE, HALTED, MEM_ERR;
`ifdef UC_TRAP_EN
  logic       TRAP_SEL;
`endif

  int total = 0;
  int bad   = 0;

  uc_multiciclo_param dut (
    .CLK(CLK), .RESET(RESET), .IR6_0(IR6_0), .IR14_12(IR14_12), .IR30(IR30),
    .IGUAL(IGUAL), .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR),
    .IR_WIRE(IR_WIRE), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC), .ALU_SRCA(ALU_SRCA),
    .ALU_SRCB(ALU_SRCB), .ALU_SELECTOR(ALU_SELECTOR), .LOAD_A(LOAD_A), .LOAD_B(LOAD_B),
    .LOAD_ALUOUT(LOAD_ALUOUT), .LOAD_MDR(LOAD_MDR), .BANCO_WIRE(BANCO_WIRE),
    .MEM_TO_REG(MEM_TO_REG), .HALTED(HALTED), .MEM_ERR(MEM_ERR)
`ifdef UC_TRAP_EN
    , .TRAP_SEL(TRAP_SEL)
`endif
  );

  always #5 CLK = ~CLK;

  // Packed control word: {req,wr,ir,pcw,pcs,srca} srcb sel {la,lb,lao,lmdr,bw} m2r {halted,err}
  logic [19:0] ctl;
  assign ctl = {MEM_REQ, MEM_WR, IR_WIRE, PC_WRITE, PC_SRC, ALU_SRCA, ALU_SRCB, ALU_SELECTOR,
                LOAD_A, LOAD_B, LOAD_ALUOUT, LOAD_MDR, BANCO_WIRE, MEM_TO_REG, HALTED, MEM_ERR};

  localparam logic [19:0] E_RST     = {6'b000000, 2'b00, 3'b001, 5'b00000, 2'b00, 2'b00};
  localparam logic [19:0] E_F_WAIT  = {6'b100000, 2'b01, 3'b001, 5'b00000, 2'b00, 2'b00};
  localparam logic [19:0] E_F_RDY   = {6'b101100, 2'b01, 3'b001, 5'b00000, 2'b00, 2'b00};
  localparam logic [19:0] E_DECODE  = {6'b000000, 2'b11, 3'b001, 5'b11100, 2'b00, 2'b00};
  localparam logic [19:0] E_EXEC_R  = {6'b000001, 2'b00, 3'b001, 5'b00100, 2'b00, 2'b00};
  localparam logic [19:0] E_EXEC_I  = {6'b000001, 2'b10, 3'b001, 5'b00100, 2'b00, 2'b00};
  localparam logic [19:0] E_ADDR    = {6'b000001, 2'b10, 3'b001, 5'b00100, 2'b00, 2'b00};
  localparam logic [19:0] E_RD_WAIT = {6'b100000, 2'b00, 3'b001, 5'b00000, 2'b00, 2'b00};
  localparam logic [19:0] E_RD_RDY  = {6'b100000, 2'b00, 3'b001, 5'b00010, 2'b00, 2'b00};
  localparam logic [19:0] E_ST      = {6'b110000, 2'b00, 3'b001, 5'b00000, 2'b00, 2'b00};
  localparam logic [19:0] E_WB_ALU  = {6'b000000, 2'b00, 3'b001, 5'b00001, 2'b00, 2'b00};
  localparam logic [19:0] E_WB_MEM  = {6'b000000, 2'b00, 3'b001, 5'b00001, 2'b01, 2'b00};
  localparam logic [19:0] E_WB_LUI  = {6'b000000, 2'b00, 3'b001, 5'b00001, 2'b10, 2'b00};
  localparam logic [19:0] E_BR_NT   = {6'b000001, 2'b00, 3'b111, 5'b00000, 2'b00, 2'b00};
  localparam logic [19:0] E_BR_T    = {6'b000111, 2'b00, 3'b111, 5'b00000, 2'b00, 2'b00};
  localparam logic [19:0] E_HALT    = {6'b000000, 2'b00, 3'b001, 5'b00000, 2'b00, 2'b10};
  localparam logic [19:0] E_ERR     = {6'b000000, 2'b00, 3'b001, 5'b00000, 2'b00, 2'b11};
  localparam logic [19:0] E_TRAP    = {6'b000110, 2'b00, 3'b001, 5'b00000, 2'b00, 2'b00};

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  task automatic test_reset();
    #2;
    total++;
    if (ctl !== E_RST) begin bad++; $display("FAIL reset_hold: got %h want %h", ctl, E_RST); end
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (ctl !== E_RST) begin bad++; $display("FAIL reset_edges: got %h want %h", ctl, E_RST); end
    #2 RESET = 1'b1;
    #1;
    total++;
    if (ctl !== E_F_WAIT) begin bad++; $display("FAIL reset_release: got %h want %h", ctl, E_F_WAIT); end
    $display("reset: ctl=%h", ctl);
    @(posedge CLK); #1;
  endtask

  task automatic test_alu(input string nm, input logic [6:0] opc, input logic ir30,
                          input logic [2:0] f3, input logic [2:0] sel);
    logic [19:0] ex [4];
    ex[0] = E_F_RDY;
    ex[1] = E_DECODE;
    ex[2] = (opc == OPC_R) ? {E_EXEC_R[19:12], sel, E_EXEC_R[8:0]}
                           : {E_EXEC_I[19:12], sel, E_EXEC_I[8:0]};
    ex[3] = E_WB_ALU;
    IR6_0 = opc; IR30 = ir30; IR14_12 = f3;
    for (int c = 0; c < 4; c++) begin
      MEM_READY = 1'b1;
      #1;
      total++;
      if (ctl !== ex[c]) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", nm, c, ctl, ex[c]); end
      @(posedge CLK); #1;
    end
    $display("%s: sel=%b", nm, sel);
  endtask

  task automatic test_load();
    logic [19:0] ex [8];
    bit          rd [8];
    ex = '{E_F_RDY, E_DECODE, E_ADDR, E_RD_WAIT, E_RD_WAIT, E_RD_WAIT, E_RD_RDY, E_WB_MEM};
    rd = '{1, 0, 0, 0, 0, 0, 1, 0};
    IR6_0 = OPC_LOAD; IR14_12 = 3'b011;
    for (int c = 0; c < 8; c++) begin
      MEM_READY = rd[c];
      #1;
      total++;
      if (ctl !== ex[c]) begin bad++; $display("FAIL load cycle %0d: got %h want %h", c, ctl, ex[c]); end
      @(posedge CLK); #1;
    end
    $display("load: 3 wait states");
  endtask

  task automatic test_store();
    logic [19:0] ex [5];
    bit          rd [5];
    ex = '{E_F_RDY, E_DECODE, E_ADDR, E_ST, E_ST};
    rd = '{1, 0, 0, 0, 1};
    IR6_0 = OPC_STORE;
    for (int c = 0; c < 5; c++) begin
      MEM_READY = rd[c];
      #1;
      total++;
      if (ctl !== ex[c]) begin bad++; $display("FAIL store cycle %0d: got %h want %h", c, ctl, ex[c]); end
      @(posedge CLK); #1;
    end
    $display("store: 1 wait state");
  endtask

  task automatic test_branch(input string nm, input logic [2:0] f3, input logic ig, input logic taken);
    logic [19:0] ex [3];
    ex[0] = E_F_RDY;
    ex[1] = E_DECODE;
    ex[2] = taken ? E_BR_T : E_BR_NT;
    IR6_0 = OPC_BR; IR14_12 = f3; IGUAL = ig;
    for (int c = 0; c < 3; c++) begin
      MEM_READY = 1'b1;
      #1;
      total++;
      if (ctl !== ex[c]) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", nm, c, ctl, ex[c]); end
      @(posedge CLK); #1;
    end
    $display("%s: IGUAL=%b taken=%b", nm, ig, taken);
  endtask

  task automatic test_lui_nop();
    logic [19:0] ex [6];
    int          n;
    ex = '{E_F_RDY, E_DECODE, E_WB_LUI, E_F_RDY, E_DECODE, E_TRAP};
`ifdef UC_TRAP_EN
    n = 6;
`else
    n = 5;
`endif
    for (int c = 0; c < n; c++) begin
      IR6_0 = (c < 3) ? OPC_LUI : 7'b0000000;
      MEM_READY = 1'b1;
      #1;
      total++;
      if (ctl !== ex[c]) begin bad++; $display("FAIL lui_nop cycle %0d: got %h want %h", c, ctl, ex[c]); end
`ifdef UC_TRAP_EN
      if (c == 5) begin
        total++;
        if (TRAP_SEL !== 1'b1) begin bad++; $display("FAIL trap_sel: got %b want 1", TRAP_SEL); end
      end
`endif
      @(posedge CLK); #1;
    end
    $display("lui_nop: done");
  endtask

  task automatic test_timeout();
    logic [19:0] exp;
    IR6_0 = OPC_LUI;
    // READY arriving on the 15th request cycle still completes normally
    for (int c = 0; c < 17; c++) begin
      MEM_READY = (c == 14);
      exp = (c < 14) ? E_F_WAIT : (c == 14) ? E_F_RDY : (c == 15) ? E_DECODE : E_WB_LUI;
      #1;
      total++;
      if (ctl !== exp) begin bad++; $display("FAIL to_boundary cycle %0d: got %h want %h", c, ctl, exp); end
      @(posedge CLK); #1;
    end
    for (int c = 0; c < 18; c++) begin
      MEM_READY = (c >= 15);
      exp = (c < 15) ? E_F_WAIT : E_ERR;
      #1;
      total++;
      if (ctl !== exp) begin bad++; $display("FAIL to_err cycle %0d: got %h want %h", c, ctl, exp); end
      @(posedge CLK); #1;
    end
    MEM_READY = 1'b0;
    RESET = 1'b0;
    #1;
    total++;
    if (ctl !== E_RST) begin bad++; $display("FAIL err_reset: got %h want %h", ctl, E_RST); end
    #1 RESET = 1'b1;
    #1;
    total++;
    if (ctl !== E_F_WAIT) begin bad++; $display("FAIL err_release: got %h want %h", ctl, E_F_WAIT); end
    $display("timeout: err cleared by reset, ctl=%h", ctl);
    @(posedge CLK); #1;
  endtask

  task automatic test_halt();
    logic [19:0] exp;
    IR6_0 = OPC_SYS;
    for (int c = 0; c < 22; c++) begin
      MEM_READY = (c < 2) ? 1'b1 : c[0];
      exp = (c == 0) ? E_F_RDY : (c == 1) ? E_DECODE : E_HALT;
      #1;
      total++;
      if (ctl !== exp) begin bad++; $display("FAIL halt cycle %0d: got %h want %h", c, ctl, exp); end
      @(posedge CLK); #1;
    end
    MEM_READY = 1'b0;
    RESET = 1'b0;
    #1;
    total++;
    if (ctl !== E_RST) begin bad++; $display("FAIL halt_reset: got %h want %h", ctl, E_RST); end
    #1 RESET = 1'b1;
    #1;
    total++;
    if (ctl !== E_F_WAIT) begin bad++; $display("FAIL halt_release: got %h want %h", ctl, E_F_WAIT); end
    $display("halt: 20 idle cycles");
    @(posedge CLK); #1;
  endtask

  task automatic test_async_reset();
    logic [19:0] ex [4];
    bit          rd [4];
    ex = '{E_F_RDY, E_DECODE, E_ADDR, E_ST};
    rd = '{1, 0, 0, 0};
    IR6_0 = OPC_STORE;
    for (int c = 0; c < 4; c++) begin
      MEM_READY = rd[c];
      #1;
      total++;
      if (ctl !== ex[c]) begin bad++; $display("FAIL async_pre cycle %0d: got %h want %h", c, ctl, ex[c]); end
      if (c < 3) begin @(posedge CLK); #1; end
    end
    // Mid-MEM_ST, well away from any clock edge
    #1 RESET = 1'b0;
    #1;
    total++;
    if (ctl !== E_RST) begin bad++; $display("FAIL async_reset: got %h want %h", ctl, E_RST); end
    #2 RESET = 1'b1;
    #1;
    total++;
    if (ctl !== E_F_WAIT) begin bad++; $display("FAIL async_release: got %h want %h", ctl, E_F_WAIT); end
    $display("async_reset: MEM_REQ=%b after release", MEM_REQ);
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_alu("add",  OPC_R, 1'b0, 3'b000, 3'b001);
    test_alu("sub",  OPC_R, 1'b1, 3'b000, 3'b010);
    test_alu("and",  OPC_R, 1'b0, 3'b111, 3'b011);
    test_alu("xor",  OPC_R, 1'b0, 3'b100, 3'b110);
    test_alu("slt",  OPC_R, 1'b1, 3'b010, 3'b001);
    test_alu("addi", OPC_I, 1'b1, 3'b000, 3'b001);
    test_alu("andi", OPC_I, 1'b0, 3'b111, 3'b011);
    test_load();
    test_store();
    test_branch("beq_eq", 3'b000, 1'b1, 1'b1);
    test_branch("beq_ne", 3'b000, 1'b0, 1'b0);
    test_branch("bne_eq", 3'b001, 1'b1, 1'b0);
    test_branch("bne_ne", 3'b001, 1'b0, 1'b1);
    test_lui_nop();
    test_timeout();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
